hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_pkg.sv | 20 ++
 rtl/hazard_ctrl_md_timer.sv | 33 +++
 rtl/hazard_ctrl.sv | 144 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } state_t;

  localparam logic [1:0] EXT_SIGN = 2'b00;
  localparam logic [1:0] EXT_ZERO = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  localparam logic [5:0] ANDI = 6'h0C;
  localparam logic [5:0] ORI  = 6'h0D;
  localparam logic [5:0] XORI = 6'h0E;
  localparam logic [5:0] LUI  = 6'h0F;

  localparam int unsigned MD_CNT_W = 6;

endpackage

// File: rtl/hazard_ctrl_md_timer.sv
// Loadable down-counter tracking how long a mult/div still occupies HI/LO.
module md_timer #(
  parameter int unsigned W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, HI/LO busy tracking, branch flush.
// Optional HAZARD_PERF_EN adds saturating stall/flush cycle counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MD_LAT = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic [5:0]  id_opcode,
  input  logic        id_md,
  input  logic        id_uses_hilo,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rt,
  input  logic        br_taken,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic [1:0]  ext_sel,
  output logic        md_busy,
  output logic        md_done
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  state_t               state_q, state_d;
  logic                 load_use;
  logic                 md_stall;
  logic                 md_load;
  logic                 md_zero;
  logic [MD_CNT_W-1:0]  md_cnt;

  always_comb begin
    unique case (id_opcode)
      ANDI, ORI, XORI: ext_sel = EXT_ZERO;
      LUI:             ext_sel = EXT_LUI;
      default:         ext_sel = EXT_SIGN;
    endcase
  end

  assign load_use = ex_memread && (ex_rt != '0) &&
                    ((id_uses_rs && (id_rs == ex_rt)) ||
                     (id_uses_rt && (id_rt == ex_rt)));

  always_comb begin
    state_d  = state_q;
    md_load  = 1'b0;
    md_busy  = 1'b0;
    md_done  = 1'b0;
    md_stall = 1'b0;
    unique case (state_q)
      RUN: begin
        if (id_md && !br_taken && !load_use) begin
          state_d = MD_BUSY;
          md_load = 1'b1;
        end
      end
      MD_BUSY: begin
        md_busy  = 1'b1;
        md_stall = id_md || id_uses_hilo;
        if (md_zero) begin
          md_done = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
    // Outputs are forced to idle during reset, even before the state flop clears.
    if (rst) begin
      state_d  = RUN;
      md_load  = 1'b0;
      md_busy  = 1'b0;
      md_done  = 1'b0;
      md_stall = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (!rst) begin
      if (br_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (load_use || md_stall) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end
    end
  end

  // The counter keeps running under a branch: the mult/div is older than it.
  md_timer #(.W(MD_CNT_W)) u_md_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (md_load),
    .dec      (state_q == MD_BUSY),
    .load_val (MD_CNT_W'(MD_LAT - 1)),
    .cnt      (md_cnt),
    .zero     (md_zero)
  );

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_en && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (br_taken && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl with MD_LAT=4.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_uses_rs, id_uses_rt;
  logic [5:0]  id_opcode;
  logic        id_md, id_uses_hilo, ex_memread, br_taken;
  logic        pc_en, ifid_en, ifid_flush, idex_flush, md_busy, md_done;
  logic [1:0]  ext_sel;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MD_LAT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .id_opcode    (id_opcode),
    .id_md        (id_md),
    .id_uses_hilo (id_uses_hilo),
    .ex_memread   (ex_memread),
    .ex_rt        (ex_rt),
    .br_taken     (br_taken),
    .pc_en        (pc_en),
    .ifid_en      (ifid_en),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .ext_sel      (ext_sel),
    .md_busy      (md_busy),
    .md_done      (md_done)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs = '0; id_rt = '0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    id_opcode = 6'h00; id_md = 1'b0; id_uses_hilo = 1'b0;
    ex_memread = 1'b0; ex_rt = '0; br_taken = 1'b0;
  endtask

  // Checks pipeline controls {pc_en, ifid_en, ifid_flush, idex_flush} and {md_busy, md_done}.
  task automatic ctl(input string tag, input logic [3:0] exp_pipe, input logic [1:0] exp_md);
    #1;
    check({tag, ".pipe"}, {28'd0, pc_en, ifid_en, ifid_flush, idex_flush}, {28'd0, exp_pipe});
    check({tag, ".md"},   {30'd0, md_busy, md_done}, {30'd0, exp_md});
  endtask

  localparam logic [3:0] P_RUN   = 4'b1100;
  localparam logic [3:0] P_STALL = 4'b0001;
  localparam logic [3:0] P_FLUSH = 4'b1111;

  initial begin
    idle();
    rst = 1'b1;
    tick();
    ctl("reset", P_RUN, 2'b00);
    ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
    ctl("reset_masks_lu", P_RUN, 2'b00);
    tick();
    idle();
    rst = 1'b0;
    ctl("idle", P_RUN, 2'b00);

    // Immediate extender select
    id_opcode = 6'h0D; #1; check("ext_ori",  {30'd0, ext_sel}, 32'd1);
    id_opcode = 6'h0F; #1; check("ext_lui",  {30'd0, ext_sel}, 32'd2);
    id_opcode = 6'h08; #1; check("ext_addi", {30'd0, ext_sel}, 32'd0);
    id_opcode = 6'h0C; #1; check("ext_andi", {30'd0, ext_sel}, 32'd1);
    id_opcode = 6'h0E; #1; check("ext_xori", {30'd0, ext_sel}, 32'd1);
    id_opcode = 6'h10; #1; check("ext_0x10", {30'd0, ext_sel}, 32'd0);
    idle();

    // Load-use hazards
    ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
    ctl("lu_rs", P_STALL, 2'b00);
    tick();
    ex_memread = 1'b0;
    ctl("lu_bubble_done", P_RUN, 2'b00);
    ex_memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
    ctl("lu_r0", P_RUN, 2'b00);
    idle(); ex_memread = 1'b1; ex_rt = 5'd9; id_rt = 5'd9; id_uses_rt = 1'b1;
    ctl("lu_rt", P_STALL, 2'b00);
    id_uses_rt = 1'b0; id_rs = 5'd9;
    ctl("lu_unused", P_RUN, 2'b00);
    idle(); tick();

    // MD busy window, HI/LO reader held behind it
    id_md = 1'b1;
    ctl("md_entry", P_RUN, 2'b00);
    tick();
    id_md = 1'b0; id_uses_hilo = 1'b1;
    ctl("md_c1", P_STALL, 2'b10); tick();
    ctl("md_c2", P_STALL, 2'b10); tick();
    ctl("md_c3", P_STALL, 2'b10); tick();
    ctl("md_c4", P_STALL, 2'b11); tick();
    ctl("md_c5", P_RUN,   2'b00);
    idle(); tick();

    // Independent instructions run under MD_BUSY; a branch overrides the HI/LO stall
    id_md = 1'b1; tick(); id_md = 1'b0;
    ctl("mdb_c1_free", P_RUN, 2'b10); tick();
    id_uses_hilo = 1'b1; br_taken = 1'b1;
    ctl("mdb_c2_br", P_FLUSH, 2'b10); tick();
    br_taken = 1'b0;
    ctl("mdb_c3", P_STALL, 2'b10); tick();
    ctl("mdb_c4", P_STALL, 2'b11); tick();
    ctl("mdb_c5", P_RUN,   2'b00);
    idle(); tick();

    // MD coincident with a branch is squashed
    id_md = 1'b1; br_taken = 1'b1;
    ctl("md_br", P_FLUSH, 2'b00); tick();
    idle();
    ctl("md_br_next", P_RUN, 2'b00);

    // Reset at the second MD_BUSY cycle abandons the operation
    id_md = 1'b1; tick(); id_md = 1'b0; id_uses_hilo = 1'b1;
    ctl("mdr_c1", P_STALL, 2'b10); tick();
    rst = 1'b1;
    ctl("mdr_rst", P_RUN, 2'b00); tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ctl("mdr_after", P_RUN, 2'b00);
      tick();
    end
    idle();

`ifdef HAZARD_PERF_EN
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ex_memread = 1'b1; ex_rt = 5'd3; id_rs = 5'd3; id_uses_rs = 1'b1;
      tick(); idle(); tick();
    end
    for (int i = 0; i < 2; i++) begin
      br_taken = 1'b1; tick(); idle(); tick();
    end
    check("stall_cnt", stall_cnt, 32'd3);
    check("flush_cnt", flush_cnt, 32'd2);
    rst = 1'b1; tick();
    check("stall_cnt_rst", stall_cnt, 32'd0);
    check("flush_cnt_rst", flush_cnt, 32'd0);
    rst = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
